addroundkey_seq: RTL and testbench

Sequential, parametrised AddRoundKey stage for the AES engine. It XORs a 128-bit state block with one round key selected from the expanded key. The XOR is done DW bits per cycle, so area can be traded against latency. A start/finish handshake, a busy flag and an out-of-range round error let the round controller sequence it for AES-128, AES-192 and AES-256.

---
 rtl/addroundkey_seq.sv | 113 +++++++++++
 tb/tb_addroundkey_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/addroundkey_seq.sv
// addroundkey_seq: sequential AES AddRoundKey. XORs a 128-bit state with one
// selected round key, DW bits per clock, behind a start/finish handshake.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; out holds the last result
// S_RUN  | one lane XORed per edge, busy high
// S_DONE | single cycle with finish high; start here is accepted again
module addroundkey_seq #(
  parameter int NR = 10,
  parameter int DW = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [127:0]            state,
  input  logic [(NR+1)*128-1:0]   key,
  input  logic [3:0]              roundnumber,
  input  logic                    start,
  output logic [127:0]            out,
  output logic                    finish,
  output logic                    busy,
  output logic                    err
);

  localparam int LANES = 128 / DW;
  localparam int LCW   = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

  fsm_t             r_fsm;
  fsm_t             w_fsm_nxt;
  logic [LCW-1:0]   r_lcnt;
  logic [127:0]     r_work;
  logic [127:0]     r_keyr;
  logic [127:0]     r_out;
  logic             r_err;
  logic             r_err_pend;
  logic             w_accept;
  logic             w_last;
  logic             w_bad;
  logic [127:0]     w_key_sel;
  logic [127:0]     w_work_nxt;

  assign w_accept = start && (r_fsm != S_RUN);
  assign w_last   = (r_lcnt == LCW'(LANES - 1));
  assign w_bad    = ({28'd0, roundnumber} > 32'(NR));
  assign out      = r_out;
  assign err      = r_err;

  // Round key mux; indices above NR select zero so the state passes through.
  always_comb begin
    w_key_sel = '0;
    for (int r = 0; r <= NR; r++) begin
      if (roundnumber == 4'(r)) w_key_sel = key[r*128 +: 128];
    end
  end

  // Working word with the current lane XORed in (lane 0 = LSBs).
  always_comb begin
    w_work_nxt = r_work;
    for (int l = 0; l < LANES; l++) begin
      if (r_lcnt == LCW'(l)) w_work_nxt[l*DW +: DW] = r_work[l*DW +: DW] ^ r_keyr[l*DW +: DW];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= S_IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  // FSM next-state logic; start during RUN is dropped, not queued.
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:  if (start) w_fsm_nxt = S_RUN;
      S_RUN:   if (w_last) w_fsm_nxt = S_DONE;
      S_DONE:  w_fsm_nxt = start ? S_RUN : S_IDLE;
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  // FSM outputs; busy and finish are decoded from disjoint states.
  always_comb begin
    busy   = (r_fsm == S_RUN);
    finish = (r_fsm == S_DONE);
  end

  // Datapath: capture on accept, one lane per RUN edge, publish on the last lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lcnt     <= '0;
      r_work     <= '0;
      r_keyr     <= '0;
      r_out      <= '0;
      r_err      <= 1'b0;
      r_err_pend <= 1'b0;
    end else if (w_accept) begin
      r_work     <= state;
      r_keyr     <= w_key_sel;
      r_lcnt     <= '0;
      r_err_pend <= w_bad;
    end else if (r_fsm == S_RUN) begin
      r_work <= w_work_nxt;
      r_lcnt <= r_lcnt + LCW'(1);
      if (w_last) begin
        r_out <= w_work_nxt;
        r_err <= r_err_pend;
      end
    end
  end

endmodule

// File: tb/tb_addroundkey_seq.sv
// Directed bench for addroundkey_seq across four DW/NR configurations.
module tb_addroundkey_seq;

  logic            clk;
  logic            rst_n;
  logic [127:0]    st;
  logic [3:0]      rn;
  logic [11*128-1:0] key10;
  logic [15*128-1:0] key14;
  logic            start32, start128, start8, start64;
  logic [127:0]    out32, out128, out8, out64;
  logic            fin32, fin128, fin8, fin64;
  logic            busy32, busy128, busy8, busy64;
  logic            err32, err128, err8, err64;

  int n_chk = 0;
  int n_err = 0;

  addroundkey_seq #(.NR(10), .DW(32)) u32 (
    .clk(clk), .rst_n(rst_n), .state(st), .key(key10), .roundnumber(rn), .start(start32),
    .out(out32), .finish(fin32), .busy(busy32), .err(err32));
  addroundkey_seq #(.NR(14), .DW(128)) u128 (
    .clk(clk), .rst_n(rst_n), .state(st), .key(key14), .roundnumber(rn), .start(start128),
    .out(out128), .finish(fin128), .busy(busy128), .err(err128));
  addroundkey_seq #(.NR(10), .DW(8)) u8 (
    .clk(clk), .rst_n(rst_n), .state(st), .key(key10), .roundnumber(rn), .start(start8),
    .out(out8), .finish(fin8), .busy(busy8), .err(err8));
  addroundkey_seq #(.NR(10), .DW(64)) u64 (
    .clk(clk), .rst_n(rst_n), .state(st), .key(key10), .roundnumber(rn), .start(start64),
    .out(out64), .finish(fin64), .busy(busy64), .err(err64));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] b;
    rst_n = 1'b0;
    st = '0; rn = '0;
    start32 = 0; start128 = 0; start8 = 0; start64 = 0;
    // NR=10 rounds: round r = {16{8'h10+r}}, round 0 overridden below
    for (int r = 0; r <= 10; r++) begin
      b = 8'h10 + 8'(r);
      key10[r*128 +: 128] = {16{b}};
    end
    key10[127:0] = 128'h000102030405060708090a0b0c0d0e0f;
    // NR=14 rounds: round r = {16{8'(r)}}
    for (int r = 0; r <= 14; r++) begin
      b = 8'(r);
      key14[r*128 +: 128] = {16{b}};
    end

    step(); step();
    chk("rst_out",    out32, 128'h0);
    chk("rst_busy",   {127'b0, busy32}, 128'h0);
    chk("rst_finish", {127'b0, fin32}, 128'h0);
    chk("rst_err",    {127'b0, err32}, 128'h0);
    rst_n = 1'b1;
    step();

    // Basic round 0, DW=32
    st = 128'h00112233445566778899aabbccddeeff; rn = 4'd0; start32 = 1;
    step(); start32 = 0;
    chk("b32_busy_e0", {127'b0, busy32}, 128'h1);
    chk("b32_fin_e0",  {127'b0, fin32}, 128'h0);
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i < 4) begin
        chk("b32_busy_run", {127'b0, busy32}, 128'h1);
        chk("b32_fin_run",  {127'b0, fin32}, 128'h0);
      end else begin
        chk("b32_fin",  {127'b0, fin32}, 128'h1);
        chk("b32_busy_done", {127'b0, busy32}, 128'h0);
        chk("b32_out",  out32, 128'h00102030405060708090a0b0c0d0e0f0);
        chk("b32_err",  {127'b0, err32}, 128'h0);
      end
    end
    step();
    chk("b32_fin_drop", {127'b0, fin32}, 128'h0);
    chk("b32_out_hold", out32, 128'h00102030405060708090a0b0c0d0e0f0);

    // Round selection, DW=128, NR=14
    st = '0; rn = 4'd14; start128 = 1;
    step(); start128 = 0;
    chk("r128_busy", {127'b0, busy128}, 128'h1);
    step();
    chk("r128_fin", {127'b0, fin128}, 128'h1);
    chk("r128_out", out128, {16{8'h0e}});
    chk("r128_err", {127'b0, err128}, 128'h0);
    step();
    st = 128'h0123456789abcdeffedcba9876543210; rn = 4'd15; start128 = 1;
    step(); start128 = 0;
    step();
    chk("r128_bad_fin", {127'b0, fin128}, 128'h1);
    chk("r128_bad_out", out128, 128'h0123456789abcdeffedcba9876543210);
    chk("r128_bad_err", {127'b0, err128}, 128'h1);
    step();
    st = '0; rn = 4'd3; start128 = 1;
    step(); start128 = 0;
    step();
    chk("r128_clr_out", out128, {16{8'h03}});
    chk("r128_clr_err", {127'b0, err128}, 128'h0);
    step();

    // Start during RUN ignored, DW=8
    st = 128'h00112233445566778899aabbccddeeff; rn = 4'd2; start8 = 1;
    step(); start8 = 0;
    st = 128'hffffffffffffffffffffffffffffffff; rn = 4'd5;
    for (int e = 1; e <= 16; e++) begin
      if (e == 3 || e == 9) start8 = 1;
      step();
      start8 = 0;
      if (e < 16) chk("b8_nofin", {127'b0, fin8}, 128'h0);
      else begin
        chk("b8_fin", {127'b0, fin8}, 128'h1);
        chk("b8_out", out8, 128'h12033021564774659a8bb8a9decffced);
      end
    end
    step();
    chk("b8_single_fin", {127'b0, fin8}, 128'h0);
    chk("b8_idle_busy",  {127'b0, busy8}, 128'h0);

    // Back-to-back, DW=64
    st = '0; rn = 4'd1; start64 = 1;
    step();
    st = 128'hffffffffffffffffffffffffffffffff; rn = 4'd4;
    for (int e = 1; e <= 9; e++) begin
      step();
      if (e == 3) begin st = {16{8'h1a}}; rn = 4'd10; end
      if (e == 6) start64 = 0;
      chk("b64_fin", {127'b0, fin64}, {127'b0, (e == 2 || e == 5 || e == 8)});
      chk("b64_busy", {127'b0, busy64}, {127'b0, !(e == 2 || e == 5 || e == 8 || e == 9)});
      if (e == 2) chk("b64_out1", out64, {16{8'h11}});
      if (e == 5) chk("b64_out2", out64, {16{8'heb}});
      if (e == 8) begin
        chk("b64_out3", out64, 128'h0);
        chk("b64_err3", {127'b0, err64}, 128'h0);
      end
    end
    // First out-of-range index for NR=10
    st = 128'hdeadbeef00000000cafef00d12345678; rn = 4'd11; start64 = 1;
    step(); start64 = 0;
    step(); step();
    chk("b64_bad_out", out64, 128'hdeadbeef00000000cafef00d12345678);
    chk("b64_bad_err", {127'b0, err64}, 128'h1);
    step();

    // Reset mid-operation, DW=32
    st = 128'hffffffffffffffffffffffffffffffff; rn = 4'd0; start32 = 1;
    step(); start32 = 0;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_out",  out32, 128'h0);
    chk("rstm_busy", {127'b0, busy32}, 128'h0);
    chk("rstm_fin",  {127'b0, fin32}, 128'h0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rstm_nofin", {127'b0, fin32}, 128'h0);
    end
    st = 128'h00112233445566778899aabbccddeeff; rn = 4'd1; start32 = 1;
    step(); start32 = 0;
    step(); step(); step(); step();
    chk("rstm_fresh_fin", {127'b0, fin32}, 128'h1);
    chk("rstm_fresh_out", out32, 128'h11003322554477669988bbaaddccffee);
    chk("rstm_fresh_err", {127'b0, err32}, 128'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
